// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Captures decoded control, operands and register specifiers from ID every
// cycle. It inserts a bubble (control cleared, EX_Valid=0) on a load-use
// request or a branch/jump flush, and holds when IDEXWrite=0.
// EX_MemRead and EX_WriteReg go back to the hazard unit to close the
// load-use loop. Two saturating event counters record bubble cycles.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   IDEXClearCtrl          load-use bubble request
//   Flush                  branch/jump flush request (wins over everything)
//   IDEXWrite              update enable, 0 = hold
//   ID_*                   decoded control, ALU op, data and fields from ID
//   EX_*                   registered copies for the EX stage
//   EX_WriteReg            EX_RegDst ? EX_rd : EX_rt (combinational)
//   EX_Valid               1 = real instruction, 0 = bubble
//   StallCount/FlushCount  saturating bubble-cycle counters
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IDEXClearCtrl,
  input  logic              Flush,
  input  logic              IDEXWrite,
  input  logic              ID_RegWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_Branch,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [DATA_W-1:0] ID_RD1,
  input  logic [DATA_W-1:0] ID_RD2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic [4:0]        ID_shamt,
  output logic              EX_RegWrite,
  output logic              EX_MemtoReg,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Branch,
  output logic              EX_ALUSrc,
  output logic              EX_RegDst,
  output logic [3:0]        EX_ALUOp,
  output logic [DATA_W-1:0] EX_PC4,
  output logic [DATA_W-1:0] EX_RD1,
  output logic [DATA_W-1:0] EX_RD2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_rd,
  output logic [4:0]        EX_shamt,
  output logic [4:0]        EX_WriteReg,
  output logic              EX_Valid,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Control bits packed as {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst}
  logic [6:0]        id_ctrl_s;
  logic              bubble_s;
  logic              load_data_s;

  logic [6:0]        ctrl_q,  ctrl_d;
  logic [3:0]        aluop_q, aluop_d;
  logic [DATA_W-1:0] pc4_q,   pc4_d;
  logic [DATA_W-1:0] rd1_q,   rd1_d;
  logic [DATA_W-1:0] rd2_q,   rd2_d;
  logic [DATA_W-1:0] imm_q,   imm_d;
  logic [4:0]        rs_q,    rs_d;
  logic [4:0]        rt_q,    rt_d;
  logic [4:0]        rd_q,    rd_d;
  logic [4:0]        shamt_q, shamt_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign id_ctrl_s = {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
                      ID_Branch, ID_ALUSrc, ID_RegDst};
  // A bubble request overrides a hold; data fields still load during a bubble.
  assign bubble_s    = Flush | IDEXClearCtrl;
  assign load_data_s = bubble_s | IDEXWrite;

  // Next-state selection for the pipeline payload: bubble > hold > load.
  always_comb begin
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    valid_d = valid_q;
    pc4_d   = pc4_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    if (bubble_s) begin
      ctrl_d  = 7'd0;
      aluop_d = 4'd0;
      valid_d = 1'b0;
    end else if (IDEXWrite) begin
      ctrl_d  = id_ctrl_s;
      aluop_d = ID_ALUOp;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
    if (load_data_s) begin
      pc4_d   = ID_PC4;
      rd1_d   = ID_RD1;
      rd2_d   = ID_RD2;
      imm_d   = ID_Imm;
      rs_d    = ID_rs;
      rt_d    = ID_rt;
      rd_d    = ID_rd;
      shamt_d = ID_shamt;
    end else begin
      pc4_d   = pc4_q;
    end
  end

  // Saturating event counters; a flush hides a simultaneous load-use request.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush) begin
      if (flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (IDEXClearCtrl) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous clear of every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= 7'd0;
      aluop_q     <= 4'd0;
      pc4_q       <= {DATA_W{1'b0}};
      rd1_q       <= {DATA_W{1'b0}};
      rd2_q       <= {DATA_W{1'b0}};
      imm_q       <= {DATA_W{1'b0}};
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      shamt_q     <= 5'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ctrl_q      <= ctrl_d;
      aluop_q     <= aluop_d;
      pc4_q       <= pc4_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      shamt_q     <= shamt_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite,
          EX_Branch, EX_ALUSrc, EX_RegDst} = ctrl_q;
  assign EX_ALUOp    = aluop_q;
  assign EX_PC4      = pc4_q;
  assign EX_RD1      = rd1_q;
  assign EX_RD2      = rd2_q;
  assign EX_Imm      = imm_q;
  assign EX_rs       = rs_q;
  assign EX_rt       = rt_q;
  assign EX_rd       = rd_q;
  assign EX_shamt    = shamt_q;
  assign EX_Valid    = valid_q;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
  // Destination register seen by the hazard unit, no extra latency.
  assign EX_WriteReg = ctrl_q[0] ? rd_q : rt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline; consumer of the hazard unit's bubble request.
- Captures ID-stage control, operands and register specifiers each cycle, and inserts a bubble on load-use stall or branch/jump flush.
- Drives EX_MemRead and EX_WriteReg back to the ID-stage hazard unit, closing the load-use detection loop.
- Holds saturating stall/flush event counters for performance debug.

Parameters:
DATA_W, 32, width of PC+4, register operands and immediate
CNT_W, 16, width of each event counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
IDEXClearCtrl  input  1  load-use bubble request from hazard unit
Flush  input  1  branch/jump flush request from EX/MEM resolution
IDEXWrite  input  1  register update enable; 0 = hold (external multi-cycle stall)
ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc, ID_RegDst  input  1 each  decoded control
ID_ALUOp  input  4  ALU operation
ID_PC4  input  DATA_W  PC+4 of the ID instruction
ID_RD1, ID_RD2  input  DATA_W  register file read data
ID_Imm  input  DATA_W  sign/zero-extended immediate
ID_rs, ID_rt, ID_rd, ID_shamt  input  5 each  instruction fields
EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_Branch, EX_ALUSrc, EX_RegDst  output  1 each  registered control
EX_ALUOp  output  4  registered ALU op
EX_PC4, EX_RD1, EX_RD2, EX_Imm  output  DATA_W  registered data
EX_rs, EX_rt, EX_rd, EX_shamt  output  5 each  registered fields (EX_rs/EX_rt feed forwarding)
EX_WriteReg  output  5  EX_RegDst ? EX_rd : EX_rt (combinational from registered fields)
EX_Valid  output  1  1 = EX holds a real instruction, 0 = bubble
StallCount  output  CNT_W  number of cycles a load-use bubble was inserted
FlushCount  output  CNT_W  number of cycles a flush bubble was inserted

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output 0, including data fields, EX_Valid and both counters; EX_WriteReg therefore 0. Reset mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Per rising edge, priority order: Flush > IDEXClearCtrl > IDEXWrite=0 (hold) > normal load.
- Normal load: all EX_* fields take the ID_* values; EX_Valid=1. Latency is one cycle.
- Bubble (Flush or IDEXClearCtrl): EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_Branch, EX_ALUSrc and EX_RegDst go to 0; EX_ALUOp=0; EX_Valid=0. Data and specifier fields still load from ID_* so the bench can check them deterministically.
- A bubble overrides hold: with IDEXWrite=0 and a bubble request together, the bubble is inserted.
- Hold (IDEXWrite=0, no bubble request): every register, including EX_Valid, keeps its value.
- Counters:
  - FlushCount increments by 1 on each edge where Flush=1.
  - Otherwise StallCount increments by 1 on each edge where IDEXClearCtrl=1.
  - If Flush and IDEXClearCtrl are both 1, only FlushCount increments.
  - Both counters saturate at 2^CNT_W-1; no wrap-around.
  - Counters count even when IDEXWrite=0.
- EX_WriteReg: purely combinational from registered EX_RegDst, EX_rd and EX_rt; no additional latency.
- Loop guarantee: a load in ID at edge N shows EX_MemRead=1 and a valid EX_WriteReg during cycle N+1. If the hazard unit requests a bubble in that cycle, EX_MemRead=0 after edge N+1, so the stall lasts exactly one cycle.

Test Plan:
- Reset: hold rst_n=0 with random ID inputs and toggling clk -> all outputs 0. Assert rst_n=0 asynchronously mid-cycle after a loaded state -> outputs 0 before the next edge.
- Normal flow: ID_RegDst=1, ID_rd=5'd9, ID_rt=5'd4, ID_RD1=32'h1234 -> after one edge EX_WriteReg=9, EX_RD1=32'h1234, EX_Valid=1. With ID_RegDst=0 -> EX_WriteReg=4.
- Load-use: lw with ID_MemRead=1 and ID_rt=8, then IDEXClearCtrl=1 for one edge -> EX_MemRead=0, EX_RegWrite=0, EX_Valid=0, StallCount=1. The next edge loads normally.
- Hold vs bubble: IDEXWrite=0 for 3 edges -> EX_* unchanged. Then IDEXWrite=0 with Flush=1 -> bubble inserted and FlushCount increments.
- Simultaneous events: Flush=1 and IDEXClearCtrl=1 on the same edge -> bubble, FlushCount+1, StallCount unchanged.
- Saturation: with CNT_W=4, assert IDEXClearCtrl for 20 edges -> StallCount stays at 15.
